// File: rtl/reg_file_pkg.sv
// Shared types and helpers for the register file: pair-operation decode.
`ifndef GLOBAL_DEFINES_SV
`include "global_defines.sv"
`endif

package reg_file_pkg;

    localparam int DEFAULT_NUM_REGS = 8;

    typedef enum logic [1:0] {
        PAIR_HOLD,
        PAIR_INC,
        PAIR_DEC
    } pair_op_e;

    // A write in the same cycle suppresses any pair update; INC with DEC cancels out.
    function automatic pair_op_e decode_pair_op(input logic cs, input logic we,
                                                 input logic inc, input logic dec);
        if (!cs || we || (inc == dec))
            return PAIR_HOLD;
        return inc ? PAIR_INC : PAIR_DEC;
    endfunction

endpackage

// File: rtl/global_defines.sv
// Project-wide shared defines, included once per compilation unit.
`ifndef GLOBAL_DEFINES_SV
`define GLOBAL_DEFINES_SV
`define DATA_WIDTH 8
`endif

// File: rtl/reg_file_pair_step.sv
// Combinational +1/-1 on a register pair, flagging wrap-around past all-ones/zero.
module reg_file_pair_step
    import reg_file_pkg::*;
#(
    parameter int W = 16
) (
    input  pair_op_e     op,
    input  logic [W-1:0] pair_in,
    output logic [W-1:0] pair_out,
    output logic         wrapped
);

    always_comb begin
        pair_out = pair_in;
        wrapped  = 1'b0;
        case (op)
            PAIR_INC: begin
                pair_out = pair_in + W'(1);
                wrapped  = &pair_in;
            end
            PAIR_DEC: begin
                pair_out = pair_in - W'(1);
                wrapped  = ~|pair_in;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/tri_state_buffer.sv
// Generic tristate driver: passes data_in through when enabled, else high-Z.
module tri_state_buffer #(
    parameter int WIDTH = 8
) (
    input  logic             enable,
    input  logic [WIDTH-1:0] data_in,
    output wire  [WIDTH-1:0] data_out
);

    assign data_out = enable ? data_in : {WIDTH{1'bz}};

endmodule

// File: rtl/reg_file.sv
// Register file with a shared tristate data bus and 16-bit pair increment/decrement
// exposed on a tristate address bus.
module reg_file
    import reg_file_pkg::*;
#(
    parameter int  DATA_WIDTH = `DATA_WIDTH,
    parameter int  NUM_REGS   = DEFAULT_NUM_REGS,
    localparam int SEL_W      = $clog2(NUM_REGS),
    localparam int PAIR_W     = (SEL_W > 1) ? SEL_W - 1 : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    CS,
    input  logic                    WE,
    input  logic                    OE,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    OE_A,
    input  logic [PAIR_W-1:0]       pair_sel,
    input  logic                    INC,
    input  logic                    DEC,
    inout  wire  [DATA_WIDTH-1:0]   data,
    output logic [DATA_WIDTH-1:0]   data_out,
    output wire  [2*DATA_WIDTH-1:0] address,
    output logic                    wrap
);

    localparam int PW = 2 * DATA_WIDTH;

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic [SEL_W-1:0]      lo_idx;
    logic [SEL_W-1:0]      hi_idx;
    logic [PW-1:0]         pair_cur;
    logic [PW-1:0]         pair_next;
    logic                  step_wrap;
    pair_op_e              op;

    // With only two registers there is a single pair, so pair_sel is ignored.
    generate
        if (SEL_W > 1) begin : g_multi_pair
            assign lo_idx = {pair_sel, 1'b0};
        end else begin : g_single_pair
            assign lo_idx = '0;
        end
    endgenerate

    assign hi_idx   = lo_idx | SEL_W'(1);
    assign pair_cur = {regs[hi_idx], regs[lo_idx]};
    assign op       = decode_pair_op(CS, WE, INC, DEC);

    reg_file_pair_step #(
        .W (PW)
    ) u_step (
        .op       (op),
        .pair_in  (pair_cur),
        .pair_out (pair_next),
        .wrapped  (step_wrap)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= '0;
            wrap <= 1'b0;
        end else begin
            wrap <= step_wrap;
            if (CS && WE) begin
                regs[sel] <= data;
            end else if (op != PAIR_HOLD) begin
                regs[lo_idx] <= pair_next[DATA_WIDTH-1:0];
                regs[hi_idx] <= pair_next[PW-1:DATA_WIDTH];
            end
        end
    end

    // WE takes the bus away from OE so the external writer never fights us.
    assign data     = (CS && OE && !WE) ? regs[sel] : {DATA_WIDTH{1'bz}};
    assign data_out = regs[sel];

    tri_state_buffer #(
        .WIDTH (PW)
    ) u_addr_buf (
        .enable   (OE_A),
        .data_in  (pair_cur),
        .data_out (address)
    );

endmodule

// File: tb/tb_reg_file.sv
// Scoreboard bench for reg_file: directed vectors queue expectations, a negedge monitor checks them.
module tb_reg_file;

    localparam int DW   = 8;
    localparam int NR   = 8;
    localparam int SW   = 3;
    localparam int PWID = 2;

    localparam logic [5:0] C_CS  = 6'b100000;
    localparam logic [5:0] C_WE  = 6'b010000;
    localparam logic [5:0] C_OE  = 6'b001000;
    localparam logic [5:0] C_OEA = 6'b000100;
    localparam logic [5:0] C_INC = 6'b000010;
    localparam logic [5:0] C_DEC = 6'b000001;

    typedef enum logic [2:0] {
        K_DATA_OUT,
        K_DATA,
        K_ADDR,
        K_WRAP,
        K_DATA_NE,
        K_ADDR_NE
    } kind_e;

    typedef struct packed {
        kind_e       kind;
        logic [15:0] exp;
    } chk_t;

    logic            clk = 1'b0;
    logic            reset;
    logic            cs, we, oe, oe_a, inc, dec;
    logic [SW-1:0]   sel;
    logic [PWID-1:0] pair_sel;
    logic [DW-1:0]   bus_drive;
    logic            tb_drive;
    wire  [DW-1:0]   data;
    logic [DW-1:0]   data_out;
    wire  [2*DW-1:0] address;
    logic            wrap;

    chk_t  exp_q[$];
    string name_q[$];
    int    n_checks = 0;
    int    n_pass   = 0;

    assign data = tb_drive ? bus_drive : {DW{1'bz}};

    always #5 clk = ~clk;

    reg_file #(
        .DATA_WIDTH (DW),
        .NUM_REGS   (NR)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .CS       (cs),
        .WE       (we),
        .OE       (oe),
        .sel      (sel),
        .OE_A     (oe_a),
        .pair_sel (pair_sel),
        .INC      (inc),
        .DEC      (dec),
        .data     (data),
        .data_out (data_out),
        .address  (address),
        .wrap     (wrap)
    );

    task automatic applyStimulus(input logic [5:0] ctl, input logic [SW-1:0] s,
                                 input logic [DW-1:0] d, input logic [PWID-1:0] p);
        cs        = ctl[5];
        we        = ctl[4];
        oe        = ctl[3];
        oe_a      = ctl[2];
        inc       = ctl[1];
        dec       = ctl[0];
        sel       = s;
        pair_sel  = p;
        bus_drive = d;
        tb_drive  = ctl[4];
    endtask

    task automatic checkOutput(input string name, input kind_e kind, input logic [15:0] exp);
        chk_t c;
        c.kind = kind;
        c.exp  = exp;
        exp_q.push_back(c);
        name_q.push_back(name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [SW-1:0] s, input logic [PWID-1:0] p);
        applyStimulus(C_OEA, s, 8'h00, p);
    endtask

    task automatic write_reg(input logic [SW-1:0] s, input logic [DW-1:0] d);
        applyStimulus(C_CS | C_WE, s, d, 2'd0);
        tick();
    endtask

    // Monitor: everything queued during a cycle is checked at the following falling edge.
    always @(negedge clk) begin
        chk_t        c;
        string       nm;
        logic [15:0] act;
        logic        ok;
        while (exp_q.size() > 0) begin
            c  = exp_q.pop_front();
            nm = name_q.pop_front();
            case (c.kind)
                K_DATA_OUT: begin act = {8'h00, data_out}; ok = (act === c.exp); end
                K_DATA:     begin act = {8'h00, data};     ok = (act === c.exp); end
                K_ADDR:     begin act = address;           ok = (act === c.exp); end
                K_WRAP:     begin act = {15'd0, wrap};     ok = (act === c.exp); end
                K_DATA_NE:  begin act = {8'h00, data};     ok = (act !== c.exp); end
                K_ADDR_NE:  begin act = address;           ok = (act !== c.exp); end
                default:    begin act = '0;                ok = 1'b0;            end
            endcase
            n_checks++;
            if (ok)
                n_pass++;
            else
                $display("[TB] FAIL %s: got 0x%0h, required %s0x%0h", nm, act,
                         (c.kind == K_DATA_NE || c.kind == K_ADDR_NE) ? "anything but " : "",
                         c.exp);
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1;
        applyStimulus(C_CS | C_OE | C_OEA, 3'd0, 8'h00, 2'd0);
        tick();
        checkOutput("reset data_out", K_DATA_OUT, 16'h0000);
        checkOutput("reset wrap", K_WRAP, 16'h0000);
        checkOutput("reset address", K_ADDR, 16'h0000);
        checkOutput("reset bus read", K_DATA, 16'h0000);
        tick();
        reset = 1'b0;
        idle(3'd0, 2'd0);
        tick();

        $display("[TB] write and bus read");
        write_reg(3'd3, 8'hA5);
        applyStimulus(C_CS | C_OE, 3'd3, 8'h00, 2'd0);
        checkOutput("bus read reg3", K_DATA, 16'h00A5);
        checkOutput("data_out reg3", K_DATA_OUT, 16'h00A5);
        tick();
        applyStimulus(C_OE, 3'd3, 8'h00, 2'd0);
        checkOutput("bus released CS low", K_DATA_NE, 16'h00A5);
        checkOutput("data_out CS low", K_DATA_OUT, 16'h00A5);
        tick();
        applyStimulus(C_WE, 3'd3, 8'h11, 2'd0);
        tick();
        idle(3'd3, 2'd0);
        checkOutput("no write without CS", K_DATA_OUT, 16'h00A5);
        tick();

        $display("[TB] pair increment with carry");
        write_reg(3'd2, 8'hFF);
        write_reg(3'd3, 8'h12);
        applyStimulus(C_CS | C_INC, 3'd0, 8'h00, 2'd1);
        tick();
        idle(3'd2, 2'd1);
        checkOutput("inc low byte", K_DATA_OUT, 16'h0000);
        checkOutput("inc carry pair1", K_ADDR, 16'h1300);
        checkOutput("inc no wrap", K_WRAP, 16'h0000);
        tick();
        applyStimulus(6'b000000, 3'd2, 8'h00, 2'd1);
        checkOutput("address released", K_ADDR_NE, 16'h1300);
        tick();
        applyStimulus(C_CS | C_DEC, 3'd0, 8'h00, 2'd1);
        tick();
        idle(3'd0, 2'd1);
        checkOutput("dec borrow pair1", K_ADDR, 16'h12FF);
        checkOutput("dec no wrap", K_WRAP, 16'h0000);
        tick();

        $display("[TB] wrap pulses");
        write_reg(3'd0, 8'hFF);
        write_reg(3'd1, 8'hFF);
        applyStimulus(C_CS | C_INC, 3'd0, 8'h00, 2'd0);
        tick();
        idle(3'd0, 2'd0);
        checkOutput("inc wrap pair0", K_ADDR, 16'h0000);
        checkOutput("inc wrap pulse", K_WRAP, 16'h0001);
        tick();
        applyStimulus(C_CS | C_DEC | C_OEA, 3'd0, 8'h00, 2'd0);
        checkOutput("wrap lasts one cycle", K_WRAP, 16'h0000);
        tick();
        idle(3'd0, 2'd0);
        checkOutput("dec wrap pair0", K_ADDR, 16'hFFFF);
        checkOutput("dec wrap pulse", K_WRAP, 16'h0001);
        tick();
        applyStimulus(C_CS | C_DEC | C_OEA, 3'd0, 8'h00, 2'd0);
        tick();
        idle(3'd0, 2'd0);
        checkOutput("dec from ffff", K_ADDR, 16'hFFFE);
        checkOutput("dec ffff no wrap", K_WRAP, 16'h0000);
        tick();

        $display("[TB] priority and cancellation");
        write_reg(3'd0, 8'h10);
        write_reg(3'd1, 8'h00);
        applyStimulus(C_CS | C_WE | C_INC | C_OEA, 3'd0, 8'h55, 2'd0);
        tick();
        idle(3'd0, 2'd0);
        checkOutput("write beats inc", K_ADDR, 16'h0055);
        checkOutput("write beats inc wrap", K_WRAP, 16'h0000);
        tick();
        applyStimulus(C_CS | C_WE | C_INC, 3'd5, 8'h9A, 2'd1);
        tick();
        idle(3'd5, 2'd1);
        checkOutput("write reg5", K_DATA_OUT, 16'h009A);
        checkOutput("write blocks other pair", K_ADDR, 16'h12FF);
        tick();
        applyStimulus(C_CS | C_INC | C_DEC, 3'd0, 8'h00, 2'd0);
        tick();
        idle(3'd0, 2'd0);
        checkOutput("inc+dec no change", K_ADDR, 16'h0055);
        checkOutput("inc+dec no wrap", K_WRAP, 16'h0000);
        tick();
        applyStimulus(C_INC | C_OEA, 3'd0, 8'h00, 2'd0);
        tick();
        idle(3'd0, 2'd0);
        checkOutput("cs low freezes pair", K_ADDR, 16'h0055);
        tick();

        $display("[TB] back-to-back increments");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(C_CS | C_INC | C_OEA, 3'd4, 8'h00, 2'd2);
            checkOutput("b2b inc step", K_ADDR, 16'(16'h9A00 + i));
            tick();
        end
        idle(3'd4, 2'd2);
        checkOutput("b2b inc final", K_ADDR, 16'h9A03);
        tick();

        $display("[TB] asynchronous reset");
        for (int i = 0; i < NR; i++)
            write_reg(SW'(i), 8'h77);
        idle(3'd6, 2'd1);
        checkOutput("preload reg6", K_DATA_OUT, 16'h0077);
        checkOutput("preload pair1", K_ADDR, 16'h7777);
        tick();
        #2;
        reset = 1'b1;
        checkOutput("async reset reg6", K_DATA_OUT, 16'h0000);
        checkOutput("async reset pair1", K_ADDR, 16'h0000);
        tick();
        applyStimulus(C_CS | C_INC | C_OEA, 3'd0, 8'h00, 2'd0);
        tick();
        reset = 1'b0;
        checkOutput("inc during reset discarded", K_ADDR, 16'h0000);
        tick();
        idle(3'd7, 2'd0);
        checkOutput("first inc after reset", K_ADDR, 16'h0001);
        checkOutput("reg7 cleared", K_DATA_OUT, 16'h0000);
        tick();

        for (int k = 0; k < 20 && exp_q.size() != 0; k++)
            @(negedge clk);
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("[TB] FAIL scoreboard drain: %0d pending, required 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 Parameter DATA_WIDTH, default `DATA_WIDTH (8), width of each register and of the data bus.
REQ-002 Parameter NUM_REGS, default 8, register count; SHALL be an even power of two, at least 2.
REQ-003 Derived SEL_W = clog2(NUM_REGS), PAIR_W = SEL_W-1 (minimum 1).
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 CS  input  1  chip select; gates WE, OE, INC and DEC.
REQ-007 WE  input  1  write selected register from data bus.
REQ-008 OE  input  1  drive selected register onto data bus.
REQ-009 sel  input  SEL_W  register index for WE/OE/data_out.
REQ-010 OE_A  input  1  drive the selected register pair onto address.
REQ-011 pair_sel  input  PAIR_W  pair index k; pair = {reg[2k+1], reg[2k]}, high byte odd.
REQ-012 INC  input  1  increment selected pair as one 2*DATA_WIDTH value.
REQ-013 DEC  input  1  decrement selected pair as one 2*DATA_WIDTH value.
REQ-014 data  inout  DATA_WIDTH  shared tristate data bus.
REQ-015 data_out  output  DATA_WIDTH  reg[sel], always driven, combinational.
REQ-016 address  output  2*DATA_WIDTH  selected pair when OE_A, else high-Z.
REQ-017 wrap  output  1  registered pulse: previous cycle's INC/DEC wrapped.

Function
REQ-018 Write: CS&WE at rising edge SHALL load data into reg[sel]; other registers hold.
REQ-019 Bus read: data SHALL carry reg[sel] when CS&OE&!WE, else high-Z; WE overrides OE (no contention).
REQ-020 Read paths (data, data_out, address) SHALL be combinational from current register state; written value visible the cycle after the write edge.
REQ-021 INC: CS&INC&!DEC&!WE at edge SHALL set pair k to (pair k + 1) mod 2^(2*DATA_WIDTH), carry from low to high byte.
REQ-022 DEC: CS&DEC&!INC&!WE at edge SHALL set pair k to (pair k - 1) mod 2^(2*DATA_WIDTH).
REQ-023 INC and DEC together SHALL leave all registers unchanged and wrap low.
REQ-024 Priority: reset > WE > INC/DEC; any CS&WE cycle suppresses INC/DEC entirely, even on a different pair.
REQ-025 wrap SHALL be 1 for exactly the cycle after an executed INC from all-ones or DEC from zero, else 0.
REQ-026 CS low SHALL freeze all registers and release data; address/OE_A and data_out are independent of CS.
REQ-027 Back-to-back INC each cycle SHALL advance the pair by one per cycle with no bubbles.

Reset
REQ-028 reset high SHALL immediately clear every register and wrap to 0, independent of clk.
REQ-029 During reset data SHALL be high-Z unless CS&OE&!WE (drives 0); address follows OE_A (0 when driven).
REQ-030 Reset mid-INC/mid-write SHALL discard the operation; first update is at the first rising edge after reset falls.

Structure
REQ-031 DATA_WIDTH default comes from the shared global defines file; no block-local copy.
REQ-032 Address output driving SHALL reuse the existing tri_state_buffer sub-module at width 2*DATA_WIDTH.
REQ-033 Storage SHALL be a flat array of NUM_REGS DATA_WIDTH-bit registers; no latches.

Verification (DATA_WIDTH=8, NUM_REGS=8)
REQ-034 Write 0xA5 to sel=3, then CS&OE sel=3 -> data=0xA5, data_out=0xA5; CS low -> data=Z.
REQ-035 reg2=0xFF, reg3=0x12, pair_sel=1, INC one cycle -> reg2=0x00, reg3=0x13, wrap=0, address=0x1300 with OE_A.
REQ-036 pair 0 = 0xFFFF, INC -> pair 0 = 0x0000, wrap=1 for one cycle; pair 0 = 0x0000, DEC -> 0xFFFF, wrap=1.
REQ-037 Same cycle WE sel=0 data=0x55 and INC pair 0 (was 0x0010) -> reg0=0x55, reg1=0x00, wrap=0; INC+DEC together -> no change.
REQ-038 Assert reset asynchronously between edges with all registers 0x77 -> all read 0x00 before the next edge; INC after release -> pair = 0x0001.
